// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display path.
// Includes the FSM states, the digit counts and the active-low seven-segment patterns.
package score_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_DIGITS = 10;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp stays off in every entry
  localparam logic [7:0] SEG_LUT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) begin
      seg_of = SEG_BLANK;
    end else begin
      seg_of = SEG_LUT[d];
    end
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock.
// The result stays on bcd until the next start.
module bin2bcd_seq
  import score_disp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [31:0]             bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int BIN_W = 32;
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int TOT_W = BCD_W + BIN_W;

  logic [TOT_W-1:0] shift_reg;
  logic [TOT_W-1:0] adj;
  logic [TOT_W-1:0] shift_next;
  logic [4:0]       iter_reg;
  logic             busy_reg;
  logic             done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_reg[BIN_W + 4*gi +: 4];
      assign adj[BIN_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign adj[BIN_W-1:0] = shift_reg[BIN_W-1:0];
  assign shift_next     = {adj[TOT_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      iter_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start && !busy_reg) begin
        shift_reg <= {{BCD_W{1'b0}}, bin};
        iter_reg  <= '0;
        busy_reg  <= 1'b1;
      end else if (busy_reg) begin
        shift_reg <= shift_next;
        iter_reg  <= iter_reg + 5'd1;
        if (iter_reg == 5'd31) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = shift_reg[TOT_W-1:BIN_W];

endmodule

// File: rtl/score_display.sv
// Shows the binary game score on an 8-digit multiplexed seven-segment display, with
// leading-zero blanking, overflow flag and game-over blink.
module score_display
  import score_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 17,
  parameter int BLINK_BIT = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] score,
  input  logic        gameover,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        busy,
  output logic        ovf
);

  localparam int CNT_W  = BLINK_BIT + 1;
  localparam int DISP_W = 4 * NUM_DIGITS;

  logic [31:0]             s1_reg, s2_reg;
  logic [31:0]             value_reg, value_next;
  logic [31:0]             last_reg, last_next;
  state_t                  state_reg, state_next;
  logic                    busy_reg, busy_next;
  logic                    ovf_reg, ovf_next;
  logic [DISP_W-1:0]       disp_reg, disp_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic [7:0]              an_reg, an_next;
  logic [7:0]              seg_reg, seg_next;
  logic                    conv_start, conv_busy, conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd;
  logic                    accept, differs;
  logic [2:0]              sel;
  logic [7:0]              seg_digit [NUM_DIGITS];

  // score comes from another clock domain; only a value seen twice in a row is trusted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg  <= '0;
      s2_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      s1_reg  <= score;
      s2_reg  <= s1_reg;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign accept  = (s1_reg == s2_reg);
  assign differs = (s2_reg != last_reg);
  assign sel     = cnt_reg[SCAN_DIV-1 -: 3];

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (s2_reg),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      disp_reg  <= '0;
      last_reg  <= '0;
      value_reg <= '0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      ovf_reg   <= ovf_next;
      disp_reg  <= disp_next;
      last_reg  <= last_next;
      value_reg <= value_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg;
    ovf_next   = ovf_reg;
    disp_next  = disp_reg;
    last_next  = last_reg;
    value_next = value_reg;
    conv_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && differs && !conv_busy) begin
          conv_start = 1'b1;
          value_next = s2_reg;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (conv_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        disp_next  = conv_bcd[DISP_W-1:0];
        ovf_next   = |conv_bcd[4*BCD_DIGITS-1:DISP_W];
        last_next  = value_reg;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A digit is blank only when it and everything to its left is zero
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] bcd_d;
      assign bcd_d = disp_reg[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign seg_digit[gi] = seg_of(bcd_d);
      end else begin : g_upper
        logic upper_nz;
        assign upper_nz      = |disp_reg[DISP_W-1:4*gi];
        assign seg_digit[gi] = (upper_nz || ovf_reg) ? seg_of(bcd_d) : SEG_BLANK;
      end
    end
  endgenerate

  always_comb begin
    an_next  = ~(8'd1 << sel);
    seg_next = seg_digit[sel];
    if (gameover && cnt_reg[BLINK_BIT]) begin
      an_next = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg  <= 8'hFF;
      seg_reg <= SEG_BLANK;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign AN      = an_reg;
  assign SEGMENT = seg_reg;
  assign busy    = busy_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a short scan period so every digit is visited quickly.
module tb_score_display;

  logic        clk;
  logic        rst_n;
  logic [31:0] score;
  logic        gameover;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int fails  = 0;

  score_display #(
    .SCAN_DIV  (5),
    .BLINK_BIT (7)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .score    (score),
    .gameover (gameover),
    .AN       (AN),
    .SEGMENT  (SEGMENT),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string tag, output int n);
    n = 0;
    while (busy !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'd0, busy}, {63'd0, lvl});
  endtask

  // Watch one full scan (32 cycles); record each digit's pattern and check the anode walk
  task automatic scan(input string tag, input logic [63:0] exp);
    logic [7:0] seen [8];
    bit         bad;
    int         prev;
    int         idx;
    for (int i = 0; i < 8; i++) seen[i] = 8'hxx;
    bad  = 1'b0;
    prev = -1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (!$onehot(~AN)) begin
        bad = 1'b1;
      end else begin
        idx = 0;
        for (int i = 0; i < 8; i++) if (AN[i] == 1'b0) idx = i;
        if (prev >= 0 && idx != prev && idx != (prev + 1) % 8) bad = 1'b1;
        prev      = idx;
        seen[idx] = SEGMENT;
      end
    end
    check({tag, " onehot"}, {63'd0, bad}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s d%0d", tag, i), {56'd0, seen[i]}, {56'd0, exp[8*i +: 8]});
    end
    $display("scan %s: digits 7..0 = %h %h %h %h %h %h %h %h", tag,
             seen[7], seen[6], seen[5], seen[4], seen[3], seen[2], seen[1], seen[0]);
  endtask

  initial begin
    int  n;
    int  ff_cnt;
    bit  seen_busy;
    bit  seg_kept;
    time t0, t1;

    // 1: reset with score 0
    rst_n    = 1'b0;
    score    = 32'd0;
    gameover = 1'b0;
    tick(3);
    check("rst AN", {56'd0, AN}, 64'hFF);
    check("rst SEGMENT", {56'd0, SEGMENT}, 64'hFF);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    seen_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    check("zero no busy", {63'd0, seen_busy}, 64'd0);
    scan("zero", 64'hFFFF_FFFF_FFFF_FFC0);

    // 2: 1234
    score = 32'd1234;
    wait_busy(1'b1, 10, "1234 start", n);
    check("1234 start latency", 64'(n), 64'd3);
    wait_busy(1'b0, 60, "1234 done", n);
    check("1234 busy cycles", 64'(n), 64'd34);
    $display("conv 1234: busy for %0d cycles", n);
    tick(1);
    check("1234 ovf", {63'd0, ovf}, 64'd0);
    scan("1234", 64'hFFFF_FFFF_F9A4_B099);

    // 3: overflow, then back to a small value
    score = 32'd100_000_000;
    wait_busy(1'b1, 10, "1e8 start", n);
    wait_busy(1'b0, 60, "1e8 done", n);
    tick(1);
    check("1e8 ovf", {63'd0, ovf}, 64'd1);
    scan("1e8", 64'hC0C0_C0C0_C0C0_C0C0);
    score = 32'd5;
    wait_busy(1'b1, 10, "5 start", n);
    wait_busy(1'b0, 60, "5 done", n);
    tick(1);
    check("5 ovf", {63'd0, ovf}, 64'd0);
    scan("5", 64'hFFFF_FFFF_FFFF_FF92);

    // 4: score changes mid-conversion
    score = 32'd10;
    wait_busy(1'b1, 10, "10 start", n);
    t0 = $time;
    tick(10);
    score = 32'd11;
    wait_busy(1'b0, 60, "10 done", n);
    tick(1);
    check("11 restart busy", {63'd0, busy}, 64'd1);
    scan("10", 64'hFFFF_FFFF_FFFF_F9C0);
    wait_busy(1'b0, 80, "11 done", n);
    t1 = $time;
    $display("conv 10->11: %0d cycles total", (t1 - t0) / 10);
    check("10->11 within 72", {63'd0, ((t1 - t0) / 10) <= 72}, 64'd1);
    tick(1);
    scan("11", 64'hFFFF_FFFF_FFFF_F9F9);

    // 5: one-cycle glitch, then blink
    score = 32'd77;
    tick(1);
    score = 32'd11;
    seen_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    check("glitch no busy", {63'd0, seen_busy}, 64'd0);
    gameover = 1'b1;
    ff_cnt   = 0;
    seg_kept = 1'b0;
    repeat (256) begin
      @(negedge clk);
      if (AN == 8'hFF) begin
        ff_cnt++;
        if (SEGMENT == 8'hF9) seg_kept = 1'b1;
      end
    end
    $display("blink: AN blanked for %0d of 256 cycles", ff_cnt);
    check("blink blanked cycles", 64'(ff_cnt), 64'd128);
    check("blink segment kept", {63'd0, seg_kept}, 64'd1);
    gameover = 1'b0;
    scan("after blink", 64'hFFFF_FFFF_FFFF_F9F9);

    // 6: reset in the middle of a conversion
    score = 32'd999;
    wait_busy(1'b1, 10, "999 start", n);
    tick(20);
    rst_n = 1'b0;
    #1;
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst AN", {56'd0, AN}, 64'hFF);
    check("midrst SEGMENT", {56'd0, SEGMENT}, 64'hFF);
    check("midrst ovf", {63'd0, ovf}, 64'd0);
    tick(3);
    rst_n = 1'b1;
    wait_busy(1'b1, 10, "999 restart", n);
    check("999 restart latency", 64'(n), 64'd3);
    wait_busy(1'b0, 60, "999 done", n);
    check("999 busy cycles", 64'(n), 64'd34);
    tick(1);
    scan("999", 64'hFFFF_FFFF_FF90_9090);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
